// File: rtl/branch_pkg.sv
// ============================================================================
// Module  : branch_pkg
// Brief   : Branch-type codes, FSM state encoding and taken-decision helper
//           shared by the PC sequencer and its return-address stack.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_JMP  = 3'b011;
  localparam logic [2:0] BR_CALL = 3'b100;
  localparam logic [2:0] BR_RET  = 3'b101;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Codes 110/111 fall into the default arm and behave like NONE.
  function automatic logic br_is_taken(input logic [2:0] br_type, input logic zero);
    case (br_type)
      BR_BEQ:                  return zero;
      BR_BNE:                  return !zero;
      BR_JMP, BR_CALL, BR_RET: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_pc_unit_if.sv
// ============================================================================
// Module  : branch_pc_unit_if
// Brief   : Decode-side resolution inputs and fetch-side PC handshake of the
//           branch/PC unit, bundled as one interface.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_pc_unit_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);

  logic             stall;
  logic             fetch_ready;
  logic             id_valid;
  logic [2:0]       id_br_type;
  logic [PC_W-1:0]  id_pc;
  logic [PC_W-1:0]  id_target;
  logic             zero;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic             flush;
  logic             ras_underflow;
  logic [CNT_W-1:0] taken_cnt;

  // The PC unit itself: drives the fetch address and status.
  modport master (
    input  stall, fetch_ready, id_valid, id_br_type, id_pc, id_target, zero,
    output pc, pc_valid, flush, ras_underflow, taken_cnt
  );

  // The pipeline around it: supplies decode results and fetch readiness.
  modport slave (
    output stall, fetch_ready, id_valid, id_br_type, id_pc, id_target, zero,
    input  pc, pc_valid, flush, ras_underflow, taken_cnt
  );

endinterface

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// Module  : ras_stack
// Brief   : Circular return-address stack. A push when full overwrites the
//           oldest entry; a pop when empty leaves the stack empty.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ras_stack #(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int                PTR_W   = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  // Depth is a power of two, so the pointer wraps on its own.
  assign top   = mem[wr_ptr - PTR_W'(1)];

  // Pointer and occupancy; the count saturates at depth on overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (!full) count <= count + (PTR_W + 1)'(1);
    end else if (pop && !empty) begin
      wr_ptr <= wr_ptr - PTR_W'(1);
      count  <= count - (PTR_W + 1)'(1);
    end
  end

  // Entry storage; contents are meaningless while the count excludes them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/branch_pc_unit.sv
// ============================================================================
// Module  : branch_pc_unit
// Brief   : PC sequencer and branch resolver. Redirects the fetch PC on taken
//           branches, pulses flush, tracks CALL/RET through a small RAS and
//           counts taken redirects.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] BOOT_ADDR = '0,
  parameter int              RAS_DEPTH = 4,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_pc_unit_if.master bus
);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             flush_q, flush_d;
  logic             und_q, und_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             resolve, taken, do_call, do_ret;
  logic             ras_empty, ras_full_unused;
  logic [PC_W-1:0]  ras_top, target;

  assign resolve = bus.id_valid & ~bus.stall;
  assign taken   = resolve & br_is_taken(bus.id_br_type, bus.zero);
  assign do_call = resolve & (bus.id_br_type == BR_CALL);
  assign do_ret  = resolve & (bus.id_br_type == BR_RET);
  // An empty-stack RET falls back to the decoded target.
  assign target  = (do_ret && !ras_empty) ? ras_top : bus.id_target;

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_call),
    .pop       (do_ret),
    .push_data (bus.id_pc + PC_W'(1)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );

  // Next-state: stall holds everything, then redirect, then sequential fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    und_d      = und_q;
    cnt_d      = cnt_q;
    if (!bus.stall) begin
      if (taken) begin
        state_d = S_FLUSH;
        pc_d    = target;
        flush_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        if (do_ret && ras_empty) und_d = 1'b1;
      end else begin
        case (state_q)
          S_BOOT:  state_d = S_RUN;
          S_RUN:   if (bus.fetch_ready) pc_d = pc_q + PC_W'(1);
          S_FLUSH: state_d = S_RUN;
          default: state_d = S_BOOT;
        endcase
      end
    end
    pc_valid_d = (state_d == S_RUN);
  end

  // State and output registers; reset overrides any pending redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= BOOT_ADDR;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      und_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      und_q      <= und_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_valid      = pc_valid_q;
  assign bus.flush         = flush_q;
  assign bus.ras_underflow = und_q;
  assign bus.taken_cnt     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
// ============================================================================
// Module  : tb_branch_pc_unit
// Brief   : Bench for branch_pc_unit. A wide instance (PC_W=16, CNT_W=16)
//           and a narrow one (PC_W=4, CNT_W=2) see identical stimulus and are
//           compared each cycle against a list-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_branch_pc_unit;

  localparam int T_NONE = 0, T_BEQ = 1, T_BNE = 2, T_JMP = 3, T_CALL = 4, T_RET = 5;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_pc_unit_if #(.PC_W(16), .CNT_W(16)) bus0 ();
  branch_pc_unit_if #(.PC_W(4),  .CNT_W(2))  bus1 ();

  branch_pc_unit #(.PC_W(16), .BOOT_ADDR(16'h0), .RAS_DEPTH(DEPTH), .CNT_W(16))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  branch_pc_unit #(.PC_W(4), .BOOT_ADDR(4'h0), .RAS_DEPTH(DEPTH), .CNT_W(2))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int errors = 0;
  int checks = 0;

  // Current stimulus
  bit in_rst_n, in_stall, in_fr, in_v, in_z;
  int in_type, in_pc, in_tgt;

  // Reference model state per instance
  int pcw [2] = '{16, 4};
  int cw  [2] = '{16, 2};
  int m_pc [2];
  int m_cnt [2];
  bit m_valid [2];
  bit m_flush [2];
  bit m_und [2];
  int ras [2][DEPTH];
  int ras_n [2];

  function automatic void model_step(int k);
    int  mask = (1 << pcw[k]) - 1;
    int  cmax = (1 << cw[k]) - 1;
    bit  tk   = 1'b0;
    int  tgt  = in_tgt & mask;
    if (!in_rst_n) begin
      m_pc[k] = 0; m_valid[k] = 0; m_flush[k] = 0; m_und[k] = 0;
      m_cnt[k] = 0; ras_n[k] = 0;
      return;
    end
    if (in_stall) begin
      m_flush[k] = 0;
      return;
    end
    if (in_v) begin
      case (in_type)
        T_BEQ: tk = in_z;
        T_BNE: tk = !in_z;
        T_JMP: tk = 1'b1;
        T_CALL: begin
          tk = 1'b1;
          if (ras_n[k] == DEPTH) begin
            for (int i = 0; i < DEPTH - 1; i++) ras[k][i] = ras[k][i+1];
            ras_n[k]--;
          end
          ras[k][ras_n[k]] = (in_pc + 1) & mask;
          ras_n[k]++;
        end
        T_RET: begin
          tk = 1'b1;
          if (ras_n[k] > 0) begin
            ras_n[k]--;
            tgt = ras[k][ras_n[k]];
          end else begin
            m_und[k] = 1'b1;
          end
        end
        default: tk = 1'b0;
      endcase
    end
    if (tk) begin
      m_pc[k]    = tgt;
      m_flush[k] = 1'b1;
      m_valid[k] = 1'b0;
      if (m_cnt[k] < cmax) m_cnt[k]++;
    end else begin
      m_flush[k] = 1'b0;
      if (m_valid[k] && in_fr) m_pc[k] = (m_pc[k] + 1) & mask;
      m_valid[k] = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc0",    {16'h0, bus0.pc},          m_pc[0]);
    chk("valid0", {31'h0, bus0.pc_valid},    {31'h0, m_valid[0]});
    chk("flush0", {31'h0, bus0.flush},       {31'h0, m_flush[0]});
    chk("und0",   {31'h0, bus0.ras_underflow}, {31'h0, m_und[0]});
    chk("cnt0",   {16'h0, bus0.taken_cnt},   m_cnt[0]);
    chk("pc1",    {28'h0, bus1.pc},          m_pc[1]);
    chk("valid1", {31'h0, bus1.pc_valid},    {31'h0, m_valid[1]});
    chk("flush1", {31'h0, bus1.flush},       {31'h0, m_flush[1]});
    chk("und1",   {31'h0, bus1.ras_underflow}, {31'h0, m_und[1]});
    chk("cnt1",   {30'h0, bus1.taken_cnt},   m_cnt[1]);
  endtask

  // One clock: apply inputs, advance the model with them, compare after the edge.
  task automatic cyc(input bit r, input bit s, input bit fr, input bit v,
                     input int t, input int ip, input int tg, input bit z);
    in_rst_n = r; in_stall = s; in_fr = fr; in_v = v;
    in_type = t; in_pc = ip; in_tgt = tg; in_z = z;
    rst_n = r;
    bus0.stall = s; bus0.fetch_ready = fr; bus0.id_valid = v;
    bus0.id_br_type = 3'(t); bus0.id_pc = 16'(ip); bus0.id_target = 16'(tg); bus0.zero = z;
    bus1.stall = s; bus1.fetch_ready = fr; bus1.id_valid = v;
    bus1.id_br_type = 3'(t); bus1.id_pc = 4'(ip); bus1.id_target = 4'(tg); bus1.zero = z;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, T_NONE, 0, 0, 0);
  endtask

  initial begin
    // Reset and boot bubble
    cyc(0, 0, 1, 0, T_NONE, 0, 0, 0);
    cyc(0, 0, 1, 0, T_NONE, 0, 0, 0);
    chk("boot_pc", {16'h0, bus0.pc}, 32'h0);
    chk("boot_valid", {31'h0, bus0.pc_valid}, 32'h0);
    idle(1);
    chk("first_valid", {31'h0, bus0.pc_valid}, 32'h1);
    chk("first_pc", {16'h0, bus0.pc}, 32'h0);
    idle(3);
    chk("seq_pc3", {16'h0, bus0.pc}, 32'h3);

    // BEQ taken / not taken, BNE inverse
    cyc(1, 0, 1, 1, T_BEQ, 5, 'h40, 1);
    chk("beq_pc", {16'h0, bus0.pc}, 32'h40);
    chk("beq_flush", {31'h0, bus0.flush}, 32'h1);
    chk("beq_cnt", {16'h0, bus0.taken_cnt}, 32'h1);
    idle(2);
    cyc(1, 0, 1, 1, T_BEQ, 5, 'h40, 0);
    chk("beq_nt_pc", {16'h0, bus0.pc}, 32'h42);
    chk("beq_nt_flush", {31'h0, bus0.flush}, 32'h0);
    cyc(1, 0, 1, 1, T_BNE, 5, 'h60, 0);
    chk("bne_pc", {16'h0, bus0.pc}, 32'h60);
    idle(1);
    cyc(1, 0, 1, 1, T_BNE, 5, 'h60, 1);
    chk("bne_nt_pc", {16'h0, bus0.pc}, 32'h61);

    // CALL / RET / RET on empty stack
    cyc(1, 0, 1, 1, T_CALL, 'h10, 'h80, 0);
    chk("call_pc", {16'h0, bus0.pc}, 32'h80);
    idle(2);
    cyc(1, 0, 1, 1, T_RET, 0, 'h33, 0);
    chk("ret_pc", {16'h0, bus0.pc}, 32'h11);
    chk("ret_und", {31'h0, bus0.ras_underflow}, 32'h0);
    idle(1);
    cyc(1, 0, 1, 1, T_RET, 0, 'h22, 0);
    chk("ret_empty_pc", {16'h0, bus0.pc}, 32'h22);
    chk("ret_empty_und", {31'h0, bus0.ras_underflow}, 32'h1);
    idle(2);
    chk("und_sticky", {31'h0, bus0.ras_underflow}, 32'h1);

    // RAS overflow: five back-to-back CALLs, then RETs
    for (int i = 1; i <= 5; i++) cyc(1, 0, 1, 1, T_CALL, i, 'h90, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 1, T_RET, 0, 'h77, 0);
      chk("ovf_ret", {16'h0, bus0.pc}, 32'(6 - i));
    end
    cyc(1, 0, 1, 1, T_RET, 0, 'h55, 0);
    chk("ovf_under_pc", {16'h0, bus0.pc}, 32'h55);

    // Stall freezes a pending BEQ and clears flush
    idle(1);
    cyc(1, 0, 1, 1, T_JMP, 0, 'h30, 0);
    cyc(1, 1, 1, 1, T_BEQ, 0, 'h99, 1);
    chk("stall_pc", {16'h0, bus0.pc}, 32'h30);
    chk("stall_flush", {31'h0, bus0.flush}, 32'h0);
    chk("stall_valid", {31'h0, bus0.pc_valid}, 32'h0);
    idle(1);
    cyc(1, 0, 0, 0, T_NONE, 0, 0, 0);
    chk("hold_pc", {16'h0, bus0.pc}, 32'h30);
    cyc(1, 0, 0, 1, T_JMP, 0, 'h44, 0);
    idle(1);
    cyc(1, 0, 1, 1, T_JMP, 0, 'h48, 0);
    chk("redirect_wins", {16'h0, bus0.pc}, 32'h48);

    // Narrow-instance PC wrap
    cyc(1, 0, 1, 1, T_JMP, 0, 'h0E, 0);
    idle(3);
    chk("wrap_pc1", {28'h0, bus1.pc}, 32'h0);
    chk("nowrap_pc0", {16'h0, bus0.pc}, 32'h10);

    // Narrow-instance counter saturation
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, T_JMP, 0, 'h20, 0);
    chk("sat_cnt1", {30'h0, bus1.taken_cnt}, 32'h3);

    // Reset while flushing
    cyc(1, 0, 1, 1, T_JMP, 0, 'h50, 0);
    cyc(0, 0, 1, 1, T_JMP, 0, 'h70, 0);
    chk("rst_flush_pc", {16'h0, bus0.pc}, 32'h0);
    chk("rst_flush_flush", {31'h0, bus0.flush}, 32'h0);
    idle(1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(63) != 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
          $urandom_range(1) == 1, int'($urandom_range(7)),
          int'($urandom_range(16'hFFFF)), int'($urandom_range(16'hFFFF)),
          $urandom_range(1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter sequencer and branch resolver for the CPU.
- Consumes the 1-bit `zero` flag from the register-operand comparator (rd1 == rd2) plus the decoded branch type. Decides taken/not-taken, redirects the PC and flushes wrong-path instructions.
- Holds a small return-address stack (RAS) for CALL/RET.
- Feeds the instruction-fetch stage through a valid/ready handshake.

Parameters:
- PC_W, 16, instruction address width in bits; PC arithmetic wraps modulo 2^PC_W.
- BOOT_ADDR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- CNT_W, 16, width of the taken-branch statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  pipeline hold; freezes all state while high.
- fetch_ready  in  1  fetch stage accepts the current pc.
- id_valid  in  1  decode-stage instruction is valid.
- id_br_type  in  3  000 NONE, 001 BEQ, 010 BNE, 011 JMP, 100 CALL, 101 RET; 110/111 are treated as NONE.
- id_pc  in  PC_W  address of the decode-stage instruction.
- id_target  in  PC_W  decoded branch/jump target.
- zero  in  1  comparator result for the decode-stage operands.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  pc is presentable to fetch.
- flush  out  1  one-cycle pulse: discard fetch/decode wrong-path instructions.
- ras_underflow  out  1  sticky error: RET executed with an empty RAS.
- taken_cnt  out  CNT_W  saturating count of taken redirects.

Behaviour:
- Reset is synchronous and active-low, on a single clock `clk`:
  - rst_n=0 at a rising edge sets pc=BOOT_ADDR, pc_valid=0, flush=0, ras_underflow=0, taken_cnt=0, RAS empty, state=S_BOOT.
  - Reset asserted mid-operation overrides everything, including a pending redirect.
- FSM states: S_BOOT, S_RUN, S_FLUSH.
  - S_BOOT: pc_valid=0; next cycle goes to S_RUN unconditionally (one bubble after reset).
  - S_RUN: pc_valid=1.
  - S_FLUSH: pc_valid=0 for exactly one cycle, then S_RUN.
- Resolution is evaluated only when id_valid=1 and stall=0. Taken when:
  - BEQ and zero=1
  - BNE and zero=0
  - JMP, CALL, RET always
  - NONE never
- Redirect target:
  - id_target for BEQ/BNE/JMP/CALL.
  - RAS top for RET.
  - RET on an empty RAS: target is id_target, ras_underflow is set and stays set until reset.
- Taken branch at edge N:
  - pc ← target, flush=1 for that one cycle (registered, visible after edge N), state ← S_FLUSH.
  - taken_cnt increments, saturating at 2^CNT_W−1 (no wrap).
  - Latency from resolution to the new pc is 1 cycle; the first valid fetch of the target is at edge N+1.
- Not taken, in S_RUN: if pc_valid & fetch_ready, pc ← pc+1 (wraps at 2^PC_W−1 to 0); otherwise pc holds.
- Priority: reset > stall > taken redirect > sequential increment. A redirect wins over fetch_ready in the same cycle.
- stall=1 holds every register (pc, state, RAS, counters); flush=0 during stall.
- A redirect arriving while in S_FLUSH is legal: it re-targets pc and keeps the FSM in S_FLUSH for one more cycle.
- RAS behaviour:
  - CALL pushes id_pc+1 (mod 2^PC_W).
  - RET pops.
  - Push when full overwrites the oldest entry (circular); count stays at RAS_DEPTH; no error.
  - Pop when empty: count stays 0.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package branch_pkg holds:
  - br_type codes (BR_NONE, BR_BEQ, BR_BNE, BR_JMP, BR_CALL, BR_RET) as 3-bit localparams.
  - FSM state encoding (S_BOOT, S_RUN, S_FLUSH).
- One sub-module: ras_stack (parameters RAS_DEPTH, PC_W)
  - Ports: clk, rst_n, push, pop, push_data, top, empty, full.
  - Circular pointer plus count.
  - push and pop are never asserted together by the parent.

Test Plan:
- Reset/boot: rst_n=0 for 2 cycles, release with fetch_ready=1 → pc=0, pc_valid=0 for 1 cycle, then pc=0,1,2,3 on successive cycles.
- BEQ taken vs not: id_pc=5, id_target=0x40, BEQ with zero=1 → flush pulse, pc=0x40, taken_cnt=1. Same with zero=0 → no flush, pc keeps incrementing. Repeat with BNE for the inverse.
- CALL/RET: CALL at id_pc=0x10, target 0x80 → pc=0x80. Later RET → pc=0x11, ras_underflow=0. Then RET on the empty RAS with id_target=0x22 → pc=0x22, ras_underflow=1 and stays 1.
- RAS overflow: 5 CALLs at id_pc=1,2,3,4,5 (RAS_DEPTH=4), then 4 RETs → returns 6,5,4,3. A 5th RET underflows.
- Stall and handshake: stall=1 while a BEQ with zero=1 is presented → pc, flush and taken_cnt unchanged. fetch_ready=0 → pc holds. Redirect with fetch_ready=1 → the target wins.
- Wrap and saturation: PC_W=4, pc=15 with fetch_ready=1 → pc=0. CNT_W=2 with 5 taken JMPs → taken_cnt=3. rst_n=0 during S_FLUSH → pc=BOOT_ADDR, flush=0 next cycle.
